// File: rtl/fscpu_req_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : fscpu_req_seq_if
// Brief    : fscpu request port bundle (strobe, command, parameter, done, error)
//            shared by the command sequencer and the fscpu core.
// Revision : 1.0 - initial release
// ============================================================================
interface fscpu_req_seq_if;
  logic         req_en;
  logic [31:0]  req_cmd;
  logic [127:0] req_param;
  logic         req_done;
  logic [31:0]  req_err;

  // Sequencer side: issues requests, receives completions.
  modport master (
    output req_en,
    output req_cmd,
    output req_param,
    input  req_done,
    input  req_err
  );

  // fscpu side: receives requests, returns completions.
  modport slave (
    input  req_en,
    input  req_cmd,
    input  req_param,
    output req_done,
    output req_err
  );
endinterface
`default_nettype wire

// File: rtl/fscpu_req_seq.sv
`default_nettype none
// ============================================================================
// Module   : fscpu_req_seq
// Brief    : Queued command sequencer for the fscpu request port. Commands are
//            pushed into a small FIFO, then executed one at a time on start,
//            stopping at the first error, a timeout or an abort, and reporting
//            the outcome with a single seq_done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module fscpu_req_seq #(
  parameter int C_DEPTH_WIDTH   = 3,
  parameter int C_TIMEOUT_WIDTH = 24
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       s_wr_en,
  input  logic [31:0]                s_cmd,
  input  logic [127:0]               s_param,
  output logic                       s_full,
  output logic [C_DEPTH_WIDTH:0]     s_count,
  output logic                       s_ovf,
  input  logic                       start,
  input  logic                       abort,
  input  logic [C_TIMEOUT_WIDTH-1:0] timeout_cycles,
  fscpu_req_seq_if.master            req,
  output logic                       busy,
  output logic                       seq_done,
  output logic [31:0]                seq_err,
  output logic [C_DEPTH_WIDTH:0]     err_index
);

  localparam int C_DEPTH = 2 ** C_DEPTH_WIDTH;
  // Occupancy value meaning "full" (2^C_DEPTH_WIDTH in C_DEPTH_WIDTH+1 bits).
  localparam logic [C_DEPTH_WIDTH:0] C_FULL_CNT = {1'b1, {C_DEPTH_WIDTH{1'b0}}};
  localparam logic [31:0] C_ERR_TIMEOUT = 32'hFFFF_FFFF;
  localparam logic [31:0] C_ERR_ABORT   = 32'hFFFF_FFFE;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // FIFO storage and bookkeeping
  logic [159:0]               mem_q [C_DEPTH];
  logic [C_DEPTH_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [C_DEPTH_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [C_DEPTH_WIDTH:0]     count_q, count_d;
  logic                       full_q, full_d;
  logic                       ovf_q, ovf_d;

  // Sequencer registers
  logic                       req_en_q, req_en_d;
  logic [31:0]                req_cmd_q, req_cmd_d;
  logic [127:0]               req_param_q, req_param_d;
  logic                       busy_q, busy_d;
  logic                       seq_done_q, seq_done_d;
  logic [31:0]                seq_err_q, seq_err_d;
  logic [C_DEPTH_WIDTH:0]     err_index_q, err_index_d;
  logic [C_DEPTH_WIDTH:0]     index_q, index_d;
  logic [C_TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;

  // Control strobes from the FSM to the FIFO
  logic                       push_ok;
  logic                       pop;
  logic                       flush;
  logic                       ovf_clr;
  logic [31:0]                head_cmd;
  logic [127:0]               head_param;
  logic [C_TIMEOUT_WIDTH-1:0] tmo_inc;

  assign {head_cmd, head_param} = mem_q[rd_ptr_q];
  assign tmo_inc = tmo_q + 1'b1;

  // FIFO data write; storage needs no reset because reads are gated by occupancy.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= {s_cmd, s_param};
    end
  end

  // FIFO pointer/occupancy/overflow next-state: flush wins over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    push_ok  = s_wr_en && !full_q && !flush;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (s_wr_en && !push_ok) begin
      ovf_d = 1'b1;
    end
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    full_d = (count_d == C_FULL_CNT);
  end

  // Sequencer next-state; registered outputs are derived from the next state so
  // req_en, busy and seq_done line up with the state they belong to.
  always_comb begin
    state_d     = state_q;
    req_en_d    = 1'b0;
    req_cmd_d   = req_cmd_q;
    req_param_d = req_param_q;
    seq_err_d   = seq_err_q;
    err_index_d = err_index_q;
    index_d     = index_q;
    tmo_d       = tmo_q;
    pop         = 1'b0;
    flush       = 1'b0;
    ovf_clr     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (abort) begin
          flush = 1'b1;
        end else if (start) begin
          seq_err_d   = '0;
          err_index_d = '0;
          index_d     = '0;
          ovf_clr     = 1'b1;
          if (count_q != '0) begin
            state_d     = ST_ISSUE;
            req_en_d    = 1'b1;
            req_cmd_d   = head_cmd;
            req_param_d = head_param;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_ISSUE: begin
        if (abort) begin
          flush       = 1'b1;
          seq_err_d   = C_ERR_ABORT;
          err_index_d = index_q;
          state_d     = ST_DONE;
        end else begin
          pop     = 1'b1;
          tmo_d   = '0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (abort) begin
          flush       = 1'b1;
          seq_err_d   = C_ERR_ABORT;
          err_index_d = index_q;
          state_d     = ST_DONE;
        end else if (req.req_done) begin
          if (req.req_err == '0) begin
            index_d = index_q + 1'b1;
            if (count_q != '0) begin
              state_d     = ST_ISSUE;
              req_en_d    = 1'b1;
              req_cmd_d   = head_cmd;
              req_param_d = head_param;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            flush       = 1'b1;
            seq_err_d   = req.req_err;
            err_index_d = index_q;
            state_d     = ST_DONE;
          end
        end else begin
          tmo_d = tmo_inc;
          // Compare against the incremented value so seq_done lands
          // timeout_cycles+1 cycles after the req_en cycle.
          if ((timeout_cycles != '0) && (tmo_inc == timeout_cycles)) begin
            flush       = 1'b1;
            seq_err_d   = C_ERR_TIMEOUT;
            err_index_d = index_q;
            state_d     = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d     = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
    seq_done_d = (state_d == ST_DONE);
  end

  // State and control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      ovf_q       <= 1'b0;
      req_en_q    <= 1'b0;
      req_cmd_q   <= '0;
      req_param_q <= '0;
      busy_q      <= 1'b0;
      seq_done_q  <= 1'b0;
      seq_err_q   <= '0;
      err_index_q <= '0;
      index_q     <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      ovf_q       <= ovf_d;
      req_en_q    <= req_en_d;
      req_cmd_q   <= req_cmd_d;
      req_param_q <= req_param_d;
      busy_q      <= busy_d;
      seq_done_q  <= seq_done_d;
      seq_err_q   <= seq_err_d;
      err_index_q <= err_index_d;
      index_q     <= index_d;
      tmo_q       <= tmo_d;
    end
  end

  assign req.req_en    = req_en_q;
  assign req.req_cmd   = req_cmd_q;
  assign req.req_param = req_param_q;
  assign s_full        = full_q;
  assign s_count       = count_q;
  assign s_ovf         = ovf_q;
  assign busy          = busy_q;
  assign seq_done      = seq_done_q;
  assign seq_err       = seq_err_q;
  assign err_index     = err_index_q;

endmodule
`default_nettype wire

// File: tb/tb_fscpu_req_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fscpu_req_seq
// Brief    : Directed self-checking bench for fscpu_req_seq with a small fscpu
//            responder model and a request/completion monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fscpu_req_seq;

  logic         clk = 1'b0;
  logic         resetn;
  logic         s_wr_en;
  logic [31:0]  s_cmd;
  logic [127:0] s_param;
  logic         s_full;
  logic [3:0]   s_count;
  logic         s_ovf;
  logic         start;
  logic         abort;
  logic [23:0]  timeout_cycles;
  logic         busy;
  logic         seq_done;
  logic [31:0]  seq_err;
  logic [3:0]   err_index;

  fscpu_req_seq_if req_if ();

  // Responder model outputs and manually driven completions are merged here.
  logic        mdl_on = 1'b0;
  logic        mdl_done = 1'b0;
  logic [31:0] mdl_err = '0;
  logic        man_done = 1'b0;
  logic [31:0] man_err = '0;
  logic [31:0] err_cmd = 32'hFFFF_FF00;
  logic [31:0] err_val = '0;

  assign req_if.req_done = mdl_done | man_done;
  assign req_if.req_err  = man_done ? man_err : mdl_err;

  fscpu_req_seq #(
    .C_DEPTH_WIDTH   (3),
    .C_TIMEOUT_WIDTH (24)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .s_wr_en        (s_wr_en),
    .s_cmd          (s_cmd),
    .s_param        (s_param),
    .s_full         (s_full),
    .s_count        (s_count),
    .s_ovf          (s_ovf),
    .start          (start),
    .abort          (abort),
    .timeout_cycles (timeout_cycles),
    .req            (req_if.master),
    .busy           (busy),
    .seq_done       (seq_done),
    .seq_err        (seq_err),
    .err_index      (err_index)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log every issued request and count completion pulses.
  logic [31:0]  q_cmd [$];
  logic [127:0] q_param [$];
  int           q_cyc [$];
  int           done_cnt = 0;
  always @(negedge clk) begin
    if (req_if.req_en === 1'b1) begin
      q_cmd.push_back(req_if.req_cmd);
      q_param.push_back(req_if.req_param);
      q_cyc.push_back(cyc);
    end
    if (seq_done === 1'b1) done_cnt++;
  end

  // fscpu model: answers each request 3 cycles after its req_en cycle.
  int          pend = 0;
  logic [31:0] pend_cmd = '0;
  always @(negedge clk) begin
    mdl_done = 1'b0;
    mdl_err  = '0;
    if (!mdl_on) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mdl_done = 1'b1;
          mdl_err  = (pend_cmd == err_cmd) ? err_val : 32'h0;
        end
      end
      if (req_if.req_en === 1'b1) begin
        pend     = 3;
        pend_cmd = req_if.req_cmd;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance n cycles; inputs are driven and outputs sampled 2 time units after posedge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input logic [31:0] c, input logic [127:0] p);
    s_wr_en = 1'b1;
    s_cmd   = c;
    s_param = p;
    step(1);
    s_wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      step(1);
      if (seq_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [127:0] mkparam(input logic [31:0] c);
    return {c ^ 32'hA5A5_0000, 32'h1234_5678 + c, ~c, c};
  endfunction

  initial begin
    int          base;
    int          dbase;
    int          e;
    bit          ok;
    logic [31:0] exp_cmds [4];

    resetn         = 1'b0;
    s_wr_en        = 1'b0;
    s_cmd          = '0;
    s_param        = '0;
    start          = 1'b0;
    abort          = 1'b0;
    timeout_cycles = '0;
    step(3);

    // Reset values
    check("rst_req_en",   req_if.req_en, 1'b0);
    check("rst_req_cmd",  req_if.req_cmd, 32'h0);
    check("rst_req_param", req_if.req_param, 128'h0);
    check("rst_flags",    {busy, seq_done, s_full, s_ovf}, 4'b0000);
    check("rst_counts",   {s_count, err_index}, 8'h00);
    check("rst_seq_err",  seq_err, 32'h0);
    resetn = 1'b1;
    step(1);

    // Four-command batch config -> push -> discharge -> exe, all succeed
    mdl_on = 1'b1;
    exp_cmds[0] = 32'd29; exp_cmds[1] = 32'd0; exp_cmds[2] = 32'd2; exp_cmds[3] = 32'd30;
    for (int i = 0; i < 4; i++) push(exp_cmds[i], mkparam(exp_cmds[i]));
    check("b4_count", s_count, 4'd4);
    base  = q_cmd.size();
    dbase = done_cnt;
    pulse_start();
    check("b4_first_en",  {req_if.req_en, busy}, 2'b11);
    check("b4_first_cmd", req_if.req_cmd, 32'd29);
    wait_done(100, ok);
    check("b4_done_seen", ok, 1'b1);
    check("b4_issued", q_cmd.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      check("b4_cmd",   q_cmd[base + i], exp_cmds[i]);
      check("b4_param", q_param[base + i], mkparam(exp_cmds[i]));
    end
    check("b4_gap",       q_cyc[base + 1] - q_cyc[base], 4);
    check("b4_done_lat",  cyc - q_cyc[base + 3], 4);
    check("b4_result",    {seq_err, s_count, busy}, {32'h0, 4'd0, 1'b0});
    step(3);
    check("b4_one_done",  done_cnt - dbase, 1);
    check("b4_req_hold",  {req_if.req_en, req_if.req_cmd}, {1'b0, 32'd30});

    // Error on the second command stops the batch
    err_cmd = 32'd7;
    err_val = 32'h5;
    push(32'd6, mkparam(32'd6));
    push(32'd7, mkparam(32'd7));
    push(32'd8, mkparam(32'd8));
    base = q_cmd.size();
    pulse_start();
    wait_done(100, ok);
    check("err_done_seen", ok, 1'b1);
    check("err_issued",    q_cmd.size() - base, 2);
    check("err_seq_err",   seq_err, 32'h5);
    check("err_index",     err_index, 4'd1);
    check("err_flushed",   s_count, 4'd0);
    err_cmd = 32'hFFFF_FF00;
    err_val = '0;
    step(2);

    // Timeout with no answer, then a late done is ignored
    mdl_on = 1'b0;
    timeout_cycles = 24'd10;
    push(32'd9, mkparam(32'd9));
    pulse_start();
    e = cyc;
    check("tmo_en", req_if.req_en, 1'b1);
    wait_done(40, ok);
    check("tmo_done_seen", ok, 1'b1);
    check("tmo_latency",   cyc - e, 11);
    check("tmo_seq_err",   seq_err, 32'hFFFF_FFFF);
    check("tmo_index",     err_index, 4'd0);
    step(1);
    dbase    = done_cnt;
    man_done = 1'b1;
    man_err  = 32'h3;
    step(1);
    man_done = 1'b0;
    man_err  = '0;
    step(2);
    check("late_done_ignored", {done_cnt - dbase, busy, req_if.req_en}, {32'd0, 1'b0, 1'b0});
    check("late_keeps_err", seq_err, 32'hFFFF_FFFF);
    timeout_cycles = '0;

    // Overfill: 9 pushes into 8 slots
    mdl_on = 1'b1;
    for (int i = 0; i < 9; i++) push(32'd100 + i, mkparam(32'd100 + i));
    check("ovf_flags", {s_full, s_ovf}, 2'b11);
    check("ovf_count", s_count, 4'd8);
    base = q_cmd.size();
    pulse_start();
    check("ovf_cleared", s_ovf, 1'b0);
    wait_done(200, ok);
    check("ovf_done_seen", ok, 1'b1);
    check("ovf_issued",    q_cmd.size() - base, 8);
    check("ovf_last_cmd",  q_cmd[base + 7], 32'd107);
    check("ovf_seq_err",   seq_err, 32'h0);
    step(2);

    // Abort in WAIT coinciding with req_done
    mdl_on = 1'b0;
    push(32'd40, mkparam(32'd40));
    push(32'd41, mkparam(32'd41));
    base  = q_cmd.size();
    dbase = done_cnt;
    pulse_start();
    step(1);
    abort    = 1'b1;
    man_done = 1'b1;
    step(1);
    abort    = 1'b0;
    man_done = 1'b0;
    check("abort_done",    seq_done, 1'b1);
    check("abort_seq_err", seq_err, 32'hFFFF_FFFE);
    check("abort_flushed", {s_count, err_index}, 8'h00);
    step(3);
    check("abort_single", {done_cnt - dbase, q_cmd.size() - base}, {32'd1, 32'd1});

    // Start with an empty FIFO
    base = q_cmd.size();
    pulse_start();
    check("empty_done", {seq_done, req_if.req_en, busy}, 3'b100);
    check("empty_err",  seq_err, 32'h0);
    step(1);
    check("empty_one_pulse", {seq_done, 32'(q_cmd.size() - base)}, {1'b0, 32'd0});

    // Push during WAIT joins the running sequence
    mdl_on = 1'b1;
    push(32'd50, mkparam(32'd50));
    base  = q_cmd.size();
    dbase = done_cnt;
    pulse_start();
    step(1);
    push(32'd51, mkparam(32'd51));
    wait_done(50, ok);
    check("join_done_seen", ok, 1'b1);
    check("join_issued",    q_cmd.size() - base, 2);
    check("join_second",    q_cmd[base + 1], 32'd51);
    step(3);
    check("join_single", done_cnt - dbase, 1);

    // Abort in IDLE flushes only; a push in the flush cycle is dropped
    dbase = done_cnt;
    push(32'd60, mkparam(32'd60));
    abort   = 1'b1;
    s_wr_en = 1'b1;
    s_cmd   = 32'd61;
    step(1);
    abort   = 1'b0;
    s_wr_en = 1'b0;
    check("idle_abort", {s_count, s_ovf, seq_done}, {4'd0, 1'b1, 1'b0});
    step(2);
    check("idle_abort_nodone", done_cnt - dbase, 0);

    // Reset in the middle of a sequence
    mdl_on = 1'b0;
    push(32'd70, mkparam(32'd70));
    pulse_start();
    step(1);
    base   = q_cmd.size();
    dbase  = done_cnt;
    resetn = 1'b0;
    step(1);
    resetn = 1'b1;
    check("midrst_state", {busy, req_if.req_en, s_count, s_ovf}, {1'b0, 1'b0, 4'd0, 1'b0});
    step(5);
    check("midrst_quiet", {done_cnt - dbase, q_cmd.size() - base}, {32'd0, 32'd0});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
